// File: rtl/floo_credit_link_tx.sv
// Link-transmit stage: merges per-VC flit streams onto one registered physical
// link, arbitrating round-robin between packets and keeping wormhole packets
// contiguous. Each VC sends only while it holds receiver credits.
module floo_credit_link_tx #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic,
  parameter int unsigned NumCredits      = 4,
  parameter int unsigned CntWidth        = $clog2(NumCredits + 1),
  parameter int unsigned VcIdWidth       = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic  [NumVirtChannels-1:0]               valid_i,
  output logic  [NumVirtChannels-1:0]               ready_o,
  input  flit_t                                     data_i [NumVirtChannels],
  input  logic  [NumVirtChannels-1:0]               last_i,
  output logic                                      valid_o,
  output logic  [VcIdWidth-1:0]                     vc_id_o,
  output flit_t                                     data_o,
  input  logic  [NumVirtChannels-1:0]               credit_i,
  output logic  [NumVirtChannels-1:0][CntWidth-1:0] credits_o,
  output logic                                      error_o
);

  localparam logic [CntWidth-1:0]  MaxCredits = CntWidth'(NumCredits);
  localparam logic [VcIdWidth-1:0] LastVc     = VcIdWidth'(NumVirtChannels - 1);

  logic [NumVirtChannels-1:0][CntWidth-1:0] credits_q;
  logic [NumVirtChannels-1:0][CntWidth-1:0] credits_d;
  logic [NumVirtChannels-1:0]               eligible;
  logic [NumVirtChannels-1:0]               grant;
  logic [VcIdWidth-1:0]                     grant_idx;
  logic [VcIdWidth-1:0]                     lock_vc_q;
  logic [VcIdWidth-1:0]                     rr_ptr_q;
  logic                                     lock_q;
  logic                                     handshake;
  logic                                     overflow;
  logic                                     error_q;
  logic                                     found;
  int                                       idx;

  // A VC may send only while it has a flit and the registered counter shows a free slot
  always_comb begin
    eligible = '0;
    for (int v = 0; v < NumVirtChannels; v++) begin
      eligible[v] = valid_i[v] && (credits_q[v] != '0);
    end
  end

  // Grant the locked VC mid-packet, otherwise the first eligible VC from the pointer upwards
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (lock_q) begin
      if (eligible[lock_vc_q]) begin
        grant[lock_vc_q] = 1'b1;
        grant_idx        = lock_vc_q;
      end
    end else begin
      for (int k = 0; k < NumVirtChannels; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= int'(NumVirtChannels)) begin
          idx = idx - int'(NumVirtChannels);
        end
        if (!found && eligible[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = VcIdWidth'(idx);
        end
      end
    end
  end

  assign ready_o   = grant;
  assign handshake = |grant;

  // Register the granted flit and its VC onto the link; payload holds when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      vc_id_o <= '0;
      data_o  <= '0;
    end else begin
      valid_o <= handshake;
      if (handshake) begin
        vc_id_o <= grant_idx;
        data_o  <= data_i[grant_idx];
      end
    end
  end

  // Lock onto a VC while its packet is in flight; advance the pointer past a VC after its tail
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
    end else if (handshake) begin
      if (last_i[grant_idx]) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (grant_idx == LastVc) ? '0 : grant_idx + 1'b1;
      end else begin
        lock_q    <= 1'b1;
        lock_vc_q <= grant_idx;
      end
    end
  end

  // Sends consume a credit, returned credits refill it; a return into a full counter is an overflow
  always_comb begin
    credits_d = credits_q;
    overflow  = 1'b0;
    for (int v = 0; v < NumVirtChannels; v++) begin
      case ({grant[v], credit_i[v]})
        2'b10: credits_d[v] = credits_q[v] - 1'b1;
        2'b01: begin
          if (credits_q[v] == MaxCredits) begin
            overflow = 1'b1;
          end else begin
            credits_d[v] = credits_q[v] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Credit counters start full; the overflow flag is sticky until reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q <= {NumVirtChannels{MaxCredits}};
      error_q   <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (overflow) begin
        error_q <= 1'b1;
      end
    end
  end

  assign credits_o = credits_q;
  assign error_o   = error_q;

  // At most one VC is accepted per cycle
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ready_o));

  for (genvar v = 0; v < NumVirtChannels; v++) begin : gen_credit_chk
    // A VC with no credits must never complete a handshake, and counters never exceed the buffer depth
    a_no_send_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      !(valid_i[v] && ready_o[v] && (credits_q[v] == '0)));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      credits_q[v] <= MaxCredits);
  end

endmodule

// File: tb/tb_floo_credit_link_tx.sv
// Bench for floo_credit_link_tx: packet-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_floo_credit_link_tx;

  localparam int NumVc   = 2;
  localparam int NumCred = 4;
  localparam int CntW    = $clog2(NumCred + 1);

  typedef logic [7:0] flit_t;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic [NumVc-1:0]            valid_i = '0;
  logic [NumVc-1:0]            ready_o;
  flit_t                       data_i [NumVc];
  logic [NumVc-1:0]            last_i = '0;
  logic                        valid_o;
  logic [0:0]                  vc_id_o;
  flit_t                       data_o;
  logic [NumVc-1:0]            credit_i = '0;
  logic [NumVc-1:0][CntW-1:0]  credits_o;
  logic                        error_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: what the link and counters must show after the most recent edge
  bit    mready = 1'b0;
  int    mcred [NumVc];
  bit    mlock;
  int    mlockvc;
  int    mptr;
  bit    merr;
  bit    mvalid;
  int    mvc;
  flit_t mdata;

  floo_credit_link_tx #(
    .NumVirtChannels(NumVc),
    .flit_t         (flit_t),
    .NumCredits     (NumCred)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .last_i   (last_i),
    .valid_o  (valid_o),
    .vc_id_o  (vc_id_o),
    .data_o   (data_o),
    .credit_i (credit_i),
    .credits_o(credits_o),
    .error_o  (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Which VC the rules allow this cycle, or -1 for none
  function automatic int modelGrant();
    int cand;
    if (mlock) begin
      if (valid_i[mlockvc] && mcred[mlockvc] > 0) return mlockvc;
      return -1;
    end
    for (int k = 0; k < NumVc; k++) begin
      cand = (mptr + k) % NumVc;
      if (valid_i[cand] && mcred[cand] > 0) return cand;
    end
    return -1;
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model with this cycle's inputs
  always @(negedge clk_i) begin : cmp
    int  g;
    bit  snd;
    g = modelGrant();
    if (mready) begin
      checkOutput("cmp_valid_o", valid_o, mvalid);
      checkOutput("cmp_vc_id_o", vc_id_o, mvc);
      checkOutput("cmp_data_o", data_o, mdata);
      checkOutput("cmp_error_o", error_o, merr);
      for (int v = 0; v < NumVc; v++) begin
        checkOutput($sformatf("cmp_credits_o[%0d]", v), credits_o[v], mcred[v]);
        checkOutput($sformatf("cmp_ready_o[%0d]", v), ready_o[v], (g == v) ? 1 : 0);
      end
    end
    if (rst_i) begin
      for (int v = 0; v < NumVc; v++) mcred[v] = NumCred;
      mlock   = 1'b0;
      mlockvc = 0;
      mptr    = 0;
      merr    = 1'b0;
      mvalid  = 1'b0;
      mvc     = 0;
      mdata   = '0;
      mready  = 1'b1;
    end else begin
      mvalid = (g >= 0);
      if (g >= 0) begin
        mvc   = g;
        mdata = data_i[g];
        if (last_i[g]) begin
          mlock = 1'b0;
          mptr  = (g + 1) % NumVc;
        end else begin
          mlock   = 1'b1;
          mlockvc = g;
        end
      end
      for (int v = 0; v < NumVc; v++) begin
        snd = (g == v);
        if (snd && !credit_i[v]) mcred[v] = mcred[v] - 1;
        else if (credit_i[v] && !snd) begin
          if (mcred[v] == NumCred) merr = 1'b1;
          else mcred[v] = mcred[v] + 1;
        end
      end
    end
  end

  // Advance one clock and refresh the per-VC payloads so every flit is distinguishable
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    data_i[0] = flit_t'(cyc);
    data_i[1] = flit_t'(8'h80 | cyc);
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] l, input logic [1:0] c);
    valid_i  = v;
    last_i   = l;
    credit_i = c;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(2'b00, 2'b00, 2'b00);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin : stim
    logic [1:0] prev;
    flit_t      d;
    data_i[0] = '0;
    data_i[1] = '0;
    tick();
    doReset();
    checkOutput("rst_valid_o", valid_o, 0);
    checkOutput("rst_credits0", credits_o[0], 4);
    checkOutput("rst_credits1", credits_o[1], 4);
    checkOutput("rst_error_o", error_o, 0);

    // Single-flit packets on VC0 with no credit return drain the four credits
    $display("[TB] test 1: credit exhaustion");
    applyStimulus(2'b01, 2'b01, 2'b00);
    checkOutput("t1_ready_start", ready_o, 2'b01);
    repeat (4) tick();
    checkOutput("t1_credits0_empty", credits_o[0], 0);
    checkOutput("t1_ready_blocked", ready_o, 2'b00);
    checkOutput("t1_valid_4th", valid_o, 1);
    checkOutput("t1_vc_4th", vc_id_o, 0);
    tick();
    checkOutput("t1_valid_stop", valid_o, 0);

    // One returned credit allows exactly one more flit, one cycle later
    $display("[TB] test 2: single credit return");
    applyStimulus(2'b01, 2'b01, 2'b01);
    checkOutput("t2_ready_same_cycle", ready_o, 2'b00);
    tick();
    applyStimulus(2'b01, 2'b01, 2'b00);
    checkOutput("t2_credits0_one", credits_o[0], 1);
    checkOutput("t2_ready_after", ready_o, 2'b01);
    d = data_i[0];
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t2_valid", valid_o, 1);
    checkOutput("t2_data", data_o, d);
    checkOutput("t2_credits0_zero", credits_o[0], 0);

    // Two always-valid VCs with credits returned the cycle after each send alternate on the link
    $display("[TB] test 3: round-robin alternation");
    doReset();
    applyStimulus(2'b11, 2'b11, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      prev = ready_o;
      tick();
      applyStimulus(2'b11, 2'b11, prev);
      checkOutput("t3_valid", valid_o, 1);
      checkOutput("t3_vc", vc_id_o, (k - 1) % 2);
    end
    prev = ready_o;
    tick();
    applyStimulus(2'b00, 2'b00, prev);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t3_valid_idle", valid_o, 0);
    checkOutput("t3_credits0", credits_o[0], 4);
    checkOutput("t3_credits1", credits_o[1], 4);

    // Wormhole: a 3-flit VC0 packet stalls for credits and VC1 waits for the tail
    $display("[TB] test 4: wormhole lock with credit stall");
    doReset();
    applyStimulus(2'b01, 2'b01, 2'b00);
    tick();
    tick();
    applyStimulus(2'b10, 2'b10, 2'b00);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b10);
    tick();
    applyStimulus(2'b11, 2'b10, 2'b00);
    checkOutput("t4_pre_credits0", credits_o[0], 2);
    checkOutput("t4_pre_credits1", credits_o[1], 4);
    checkOutput("t4_ready_f1", ready_o, 2'b01);
    tick();
    checkOutput("t4_ready_f2", ready_o, 2'b01);
    checkOutput("t4_vc_f1", vc_id_o, 0);
    tick();
    checkOutput("t4_ready_stall", ready_o, 2'b00);
    checkOutput("t4_valid_f2", valid_o, 1);
    checkOutput("t4_vc_f2", vc_id_o, 0);
    tick();
    applyStimulus(2'b11, 2'b10, 2'b01);
    checkOutput("t4_ready_stall2", ready_o, 2'b00);
    checkOutput("t4_bubble", valid_o, 0);
    tick();
    applyStimulus(2'b11, 2'b11, 2'b00);
    checkOutput("t4_ready_tail", ready_o, 2'b01);
    checkOutput("t4_bubble2", valid_o, 0);
    tick();
    applyStimulus(2'b10, 2'b10, 2'b00);
    checkOutput("t4_ready_vc1", ready_o, 2'b10);
    checkOutput("t4_vc_tail", vc_id_o, 0);
    checkOutput("t4_valid_tail", valid_o, 1);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t4_vc1_flit", vc_id_o, 1);
    checkOutput("t4_vc1_valid", valid_o, 1);

    // Send and credit return on the same VC in one cycle leave the counter unchanged
    $display("[TB] test 5: simultaneous send and credit");
    doReset();
    applyStimulus(2'b10, 2'b10, 2'b00);
    tick();
    tick();
    applyStimulus(2'b10, 2'b10, 2'b10);
    checkOutput("t5_credits1_before", credits_o[1], 2);
    checkOutput("t5_ready", ready_o, 2'b10);
    d = data_i[1];
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t5_credits1_after", credits_o[1], 2);
    checkOutput("t5_valid", valid_o, 1);
    checkOutput("t5_vc", vc_id_o, 1);
    checkOutput("t5_data", data_o, d);

    // Overflow sets a sticky error; reset mid-packet clears it and the lock
    $display("[TB] test 6: overflow and mid-packet reset");
    doReset();
    applyStimulus(2'b00, 2'b00, 2'b01);
    checkOutput("t6_error_before", error_o, 0);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t6_error_set", error_o, 1);
    checkOutput("t6_credits0_full", credits_o[0], 4);
    tick();
    tick();
    checkOutput("t6_error_sticky", error_o, 1);
    applyStimulus(2'b01, 2'b00, 2'b00);
    tick();
    tick();
    checkOutput("t6_midpacket_credits0", credits_o[0], 2);
    rst_i = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00);
    tick();
    rst_i = 1'b0;
    applyStimulus(2'b10, 2'b10, 2'b00);
    checkOutput("t6_rst_valid", valid_o, 0);
    checkOutput("t6_rst_error", error_o, 0);
    checkOutput("t6_rst_credits0", credits_o[0], 4);
    checkOutput("t6_rst_credits1", credits_o[1], 4);
    checkOutput("t6_lock_cleared", ready_o, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t6_vc1_valid", valid_o, 1);
    checkOutput("t6_vc1_id", vc_id_o, 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
